// File: rtl/lcd_writer.sv
// lcd_writer: drains the LCD character FIFO onto an HD44780 8-bit parallel bus.
// Define LCD_INIT_EN to include the power-on initialization sequence.
module lcd_writer #(
  parameter int         CLOCKS_PER_US = 50,
  parameter logic [7:0] ESC_BYTE      = 8'h1B
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifo_out,
  input  logic       fifo_empty,
  output logic       fifo_out_read,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int CNT_W = $clog2(15000 * CLOCKS_PER_US + 1);
  localparam logic [CNT_W-1:0] T_STROBE = CNT_W'(CLOCKS_PER_US - 1);
  localparam logic [CNT_W-1:0] T_SHORT  = CNT_W'(40 * CLOCKS_PER_US - 1);
  localparam logic [CNT_W-1:0] T_LONG   = CNT_W'(1640 * CLOCKS_PER_US - 1);
`ifdef LCD_INIT_EN
  localparam logic [CNT_W-1:0] T_POWER  = CNT_W'(15000 * CLOCKS_PER_US - 1);
  localparam logic [CNT_W-1:0] T_FIRST  = CNT_W'(4100 * CLOCKS_PER_US - 1);
  localparam logic [2:0]       LAST_INIT = 3'd5;
  localparam logic [2:0]       INIT_DONE = 3'd6;
`endif

  typedef enum logic [2:0] {
    INIT_WAIT, INIT_CMD, IDLE, FETCH, SETUP, PULSE, HOLD, EXEC_WAIT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       byte_reg;
  logic             esc_flag, esc_n;
  logic             read_n, rs_n, e_n;
  logic [7:0]       data_n;
`ifdef LCD_INIT_EN
  logic [2:0]       init_idx, idx_n;
`endif

  // Clear/home commands need the long execution time; everything else is short.
  function automatic logic [CNT_W-1:0] exec_len(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
      return T_LONG;
    return T_SHORT;
  endfunction

`ifdef LCD_INIT_EN
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction
`endif

  assign lcd_rw = 1'b0;
  assign busy   = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - 1'b1 : '0;
    esc_n   = esc_flag;
    read_n  = 1'b0;
    rs_n    = lcd_rs;
    e_n     = lcd_e;
    data_n  = lcd_data;
`ifdef LCD_INIT_EN
    idx_n   = init_idx;
`endif
    case (state)
`ifdef LCD_INIT_EN
      INIT_WAIT: begin
        if (cnt == '0)
          state_n = INIT_CMD;
      end
      INIT_CMD: begin
        rs_n    = 1'b0;
        data_n  = init_cmd(init_idx);
        cnt_n   = T_STROBE;
        state_n = SETUP;
      end
`endif
      IDLE: begin
        if (!fifo_empty) begin
          read_n  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (byte_reg == ESC_BYTE && !esc_flag) begin
          esc_n   = 1'b1;
          state_n = IDLE;
        end else begin
          rs_n    = !esc_flag;
          data_n  = byte_reg;
          esc_n   = 1'b0;
          cnt_n   = T_STROBE;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          e_n     = 1'b1;
          cnt_n   = T_STROBE;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          e_n     = 1'b0;
          cnt_n   = T_STROBE;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          cnt_n   = exec_len(lcd_rs, lcd_data);
`ifdef LCD_INIT_EN
          if (init_idx == 3'd0)
            cnt_n = T_FIRST;
`endif
          state_n = EXEC_WAIT;
        end
      end
      EXEC_WAIT: begin
        if (cnt == '0) begin
          state_n = IDLE;
`ifdef LCD_INIT_EN
          if (init_idx != INIT_DONE) begin
            idx_n   = init_idx + 3'd1;
            state_n = (init_idx == LAST_INIT) ? IDLE : INIT_CMD;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef LCD_INIT_EN
      state    <= INIT_WAIT;
      cnt      <= T_POWER;
      init_idx <= 3'd0;
`else
      state    <= IDLE;
      cnt      <= '0;
`endif
      esc_flag      <= 1'b0;
      fifo_out_read <= 1'b0;
      lcd_rs        <= 1'b0;
      lcd_e         <= 1'b0;
      lcd_data      <= 8'h00;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      esc_flag      <= esc_n;
      fifo_out_read <= read_n;
      lcd_rs        <= rs_n;
      lcd_e         <= e_n;
      lcd_data      <= data_n;
`ifdef LCD_INIT_EN
      init_idx      <= idx_n;
`endif
    end
  end

  // Head byte captured while IDLE; it is popped on the following FETCH cycle.
  always_ff @(posedge clock) begin
    if (state == IDLE && !fifo_empty)
      byte_reg <= fifo_out;
  end

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: FIFO model, write-schedule model and a per-cycle compare process.
// Runs the power-on init scenario when LCD_INIT_EN is defined.
module tb_lcd_writer;
  localparam int         CPU = 2;
  localparam logic [7:0] ESC = 8'h1B;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fifo_out = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_out_read, lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  lcd_writer #(.CLOCKS_PER_US(CPU), .ESC_BYTE(ESC)) dut (
    .clock(clock), .reset(reset), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
    .fifo_out_read(fifo_out_read), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int at; logic rs; logic [7:0] data;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] fq[$];
  logic [7:0] bq[$];
  int         rd_cycles[$];
  int         idle_cycles[$];
  int         pushes = 0;
  int         reads = 0;
  int         n_rise = 0;
  logic       m_esc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_out   = fifo_empty ? 8'h00 : fq[0];
  endfunction

  task automatic push_fifo(input logic [7:0] b);
    fq.push_back(b);
    pushes++;
    refresh();
  endtask

  task automatic stage(input logic [7:0] b);
    push_fifo(b);
    bq.push_back(b);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (fifo_out_read && fq.size() > 0) void'(fq.pop_front());
    refresh();
  endtask

  // Expected LCD writes for a back-to-back byte stream whose first byte is sampled at 'start'.
  task automatic plan(input int start, output int t_end);
    int t;
    int wait_us;
    t = start;
    foreach (bq[i]) begin
      if (bq[i] == ESC && !m_esc) begin
        m_esc = 1'b1;
        t += 2;
      end else begin
        exp_q.push_back('{t + 2 + CPU, !m_esc, bq[i]});
        wait_us = (m_esc && (bq[i] == 8'h01 || bq[i] == 8'h02 || bq[i] == 8'h03)) ? 1640 : 40;
        m_esc = 1'b0;
        t += 2 + 3 * CPU + wait_us * CPU;
      end
    end
    bq.delete();
    t_end = t;
  endtask

`ifdef LCD_INIT_EN
  task automatic plan_init(input int release_cyc, output int t_end);
    logic [7:0] cmds[6];
    int waits[6];
    int t;
    cmds  = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    waits = '{4100, 40, 40, 40, 1640, 40};
    t = release_cyc + 15000 * CPU;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{t + 1 + CPU, 1'b0, cmds[i]});
      t += 1 + 3 * CPU + waits[i] * CPU;
    end
    t_end = t;
  endtask
`endif

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    m_esc = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && fifo_empty) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: waited %0d cycles, expected idle within %0d", tag, n, budget);
    end
    repeat (2) tick();
  endtask

  // Compare process: LCD bus protocol and write schedule, checked every cycle.
  logic       e_q = 1'b0, rd_q = 1'b0, busy_q = 1'b0, rs_q = 1'b0;
  logic [7:0] data_q = 8'h00;
  int         run = 0;
  int         rise_cyc = 0;
  wr_t        w;

  always @(negedge clock) begin
    check("rw_tied_low", {31'd0, lcd_rw}, 32'd0);
    if (lcd_rs === rs_q && lcd_data === data_q) run++;
    else run = 0;
    if (lcd_e && !e_q) begin
      n_rise++;
      rise_cyc = cyc;
      check("setup_stable", {31'd0, run >= CPU}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_e_cycle", cyc, -1);
      end else begin
        w = exp_q.pop_front();
        check("e_rise_cycle", cyc, w.at);
        check("e_rs", {31'd0, lcd_rs}, {31'd0, w.rs});
        check("e_data", {24'd0, lcd_data}, {24'd0, w.data});
      end
    end
    if (lcd_e && e_q)
      check("e_bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, rs_q, data_q});
    if (!lcd_e && e_q && !reset)
      check("e_width", cyc - rise_cyc, CPU);
    if (fifo_out_read) begin
      reads++;
      check("read_gap", {31'd0, rd_q}, 32'd0);
      check("read_not_empty", {31'd0, reads <= pushes}, 32'd1);
      rd_cycles.push_back(cyc);
    end
    if (!busy && busy_q) idle_cycles.push_back(cyc);
    e_q    = lcd_e;
    rd_q   = fifo_out_read;
    busy_q = busy;
    rs_q   = lcd_rs;
    data_q = lcd_data;
  end

  int n0, n1, tend, r0, i0, e0, cnt;

  initial begin
    refresh();
    repeat (3) tick();
`ifndef LCD_INIT_EN
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_read", {31'd0, fifo_out_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (5) begin
      tick();
      check("empty_busy", {31'd0, busy}, 32'd0);
      check("empty_read", {31'd0, fifo_out_read}, 32'd0);
      check("empty_e", {31'd0, lcd_e}, 32'd0);
    end

    // Two plain characters back to back.
    do_reset();
    r0 = rd_cycles.size(); i0 = idle_cycles.size(); e0 = n_rise;
    stage(8'h41); stage(8'h42);
    reset = 1'b0; n0 = cyc;
    plan(n0, tend);
    check("model_first_rise", exp_q[0].at, n0 + 4);
    check("model_char_end", tend, n0 + 176);
    run_until_idle(400, "chars");
    check("chars_reads", rd_cycles.size() - r0, 2);
    check("chars_read0", rd_cycles[r0], n0 + 1);
    check("chars_read1", rd_cycles[r0 + 1], n0 + 89);
    check("chars_idle0", idle_cycles[i0], n0 + 88);
    check("chars_idle1", idle_cycles[i0 + 1], n0 + 176);
    check("chars_rises", n_rise - e0, 2);

    // Escaped clear-display command.
    do_reset();
    r0 = rd_cycles.size(); i0 = idle_cycles.size(); e0 = n_rise;
    stage(ESC); stage(8'h01);
    reset = 1'b0; n0 = cyc;
    plan(n0, tend);
    check("model_clear_end", tend, n0 + 3290);
    run_until_idle(3500, "clear");
    check("clear_reads", rd_cycles.size() - r0, 2);
    check("clear_read1", rd_cycles[r0 + 1], n0 + 3);
    check("clear_idle_esc", idle_cycles[i0], n0 + 2);
    check("clear_idle_end", idle_cycles[i0 + 1], n0 + 3290);
    check("clear_rises", n_rise - e0, 1);

    // ESC ESC writes command 1B, then a character.
    do_reset();
    r0 = rd_cycles.size(); i0 = idle_cycles.size(); e0 = n_rise;
    stage(ESC); stage(ESC); stage(8'h42);
    reset = 1'b0; n0 = cyc;
    plan(n0, tend);
    check("model_escesc_rs", {31'd0, exp_q[0].rs}, 32'd0);
    check("model_escesc_rise1", exp_q[1].at, n0 + 94);
    run_until_idle(400, "escesc");
    check("escesc_reads", rd_cycles.size() - r0, 3);
    check("escesc_read2", rd_cycles[r0 + 2], n0 + 91);
    check("escesc_idle_end", idle_cycles[i0 + 2], n0 + 178);
    check("escesc_rises", n_rise - e0, 2);

    // Reset while E is high aborts the write.
    do_reset();
    r0 = rd_cycles.size(); e0 = n_rise;
    stage(8'h41); push_fifo(8'h43);
    reset = 1'b0; n0 = cyc;
    plan(n0, tend);
    cnt = 0;
    while (!lcd_e && cnt < 20) begin tick(); cnt++; end
    check("abort_rise_cycle", cyc, n0 + 4);
    reset = 1'b1;
    tick();
    check("abort_e_low", {31'd0, lcd_e}, 32'd0);
    repeat (2) tick();
    m_esc = 1'b0;
    exp_q.delete();
    bq.push_back(8'h43);
    reset = 1'b0; n1 = cyc;
    plan(n1, tend);
    run_until_idle(300, "abort");
    check("abort_reads", rd_cycles.size() - r0, 2);
    check("abort_read1", rd_cycles[r0 + 1], n1 + 1);
    check("abort_rises", n_rise - e0, 2);
    check("abort_fifo_left", fq.size(), 0);
`else
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    r0 = rd_cycles.size(); i0 = idle_cycles.size(); e0 = n_rise;
    stage(8'h41);
    reset = 1'b0; n0 = cyc;
    plan_init(n0, n1);
    check("model_init_first_rise", exp_q[0].at, n0 + 30003);
    check("model_init_end", n1, n0 + 41842);
    plan(n1, tend);
    run_until_idle(45000, "init");
    check("init_reads", rd_cycles.size() - r0, 1);
    check("init_first_read", rd_cycles[r0], n0 + 41843);
    check("init_idle", idle_cycles[i0], n0 + 41842);
    check("init_rises", n_rise - e0, 7);
    check("init_fifo_left", fq.size(), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
